rgb_breathe_pwm: RTL

RGB_BREATHE_PWM -- requirements
Module: rgb_breathe_pwm

---
 rtl/rgb_breathe_pwm.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/rgb_breathe_pwm.sv
// Breathing RGB PWM: ramps one colour channel up, holds, ramps down, holds, then advances colour.
// Optional build macro RGB_BREATHE_GAMMA_EN selects a squared brightness-to-duty curve.
module rgb_breathe_pwm #(
   parameter int unsigned STEP_PERIODS = 90,
   parameter int unsigned HOLD_PERIODS = 2048
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   output logic       pwm_r,
   output logic       pwm_g,
   output logic       pwm_b,
   output logic [1:0] color,
   output logic       cycle_done
);

   localparam int unsigned CNT_W = 8;
   localparam int unsigned PER_W = 16;
   localparam int unsigned COL_W = 2;
   localparam logic [CNT_W-1:0] LVL_MAX = '1;
   localparam logic [COL_W-1:0] COL_R = COL_W'(0);
   localparam logic [COL_W-1:0] COL_G = COL_W'(1);
   localparam logic [COL_W-1:0] COL_B = COL_W'(2);

   typedef enum logic [2:0] {
      IDLE,
      RISE,
      HOLD_HI,
      FALL,
      HOLD_LO
   } state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   pwm_cnt;
   logic [CNT_W-1:0]   brightness, bright_nxt;
   logic [CNT_W-1:0]   duty_eff, duty_nxt, duty_map;
   logic [PER_W-1:0]   period_cnt, period_nxt;
   logic [COL_W-1:0]   color_nxt;
   logic               done_nxt;
   logic               pwm_r_nxt, pwm_g_nxt, pwm_b_nxt;
   logic               tick, step_due, hold_due, pwm_on;

   assign tick     = (pwm_cnt == LVL_MAX);
   assign step_due = tick && (period_cnt == PER_W'(STEP_PERIODS - 1));
   assign hold_due = tick && (period_cnt == PER_W'(HOLD_PERIODS - 1));

   // Brightness-to-duty mapping applied when duty_eff is reloaded
`ifdef RGB_BREATHE_GAMMA_EN
   logic [2*CNT_W-1:0] bright_sq;
   always_comb begin
      bright_sq = (2*CNT_W)'(brightness) * (2*CNT_W)'(brightness);
      duty_map  = CNT_W'(bright_sq >> CNT_W);
   end
`else
   always_comb begin
      duty_map = brightness;
   end
`endif

   // Next-state, ramp, colour and PWM compare logic
   always_comb begin
      state_nxt  = state;
      bright_nxt = brightness;
      period_nxt = tick ? (period_cnt + PER_W'(1)) : period_cnt;
      color_nxt  = color;
      done_nxt   = 1'b0;
      duty_nxt   = tick ? duty_map : duty_eff;

      case (state)
         IDLE: begin
            bright_nxt = '0;
            if (en) begin
               state_nxt  = RISE;
               period_nxt = '0;
            end
         end
         RISE: begin
            if (step_due) begin
               period_nxt = '0;
               bright_nxt = (brightness == LVL_MAX) ? LVL_MAX : (brightness + CNT_W'(1));
               if (bright_nxt == LVL_MAX) state_nxt = HOLD_HI;
            end
         end
         HOLD_HI: begin
            if (hold_due) begin
               state_nxt  = FALL;
               period_nxt = '0;
            end
         end
         FALL: begin
            if (step_due) begin
               period_nxt = '0;
               bright_nxt = (brightness == '0) ? '0 : (brightness - CNT_W'(1));
               if (bright_nxt == '0) state_nxt = HOLD_LO;
            end
         end
         HOLD_LO: begin
            if (hold_due) begin
               state_nxt  = RISE;
               period_nxt = '0;
               color_nxt  = (color == COL_B) ? COL_R : (color + COL_W'(1));
               done_nxt   = (color == COL_B);
            end
         end
         default: begin
            state_nxt  = IDLE;
            period_nxt = '0;
         end
      endcase

      // Dropping enable parks the FSM dark but keeps the colour
      if (!en) begin
         state_nxt  = IDLE;
         bright_nxt = '0;
         period_nxt = '0;
         color_nxt  = color;
         done_nxt   = 1'b0;
         duty_nxt   = '0;
      end

      pwm_on    = en && (pwm_cnt < duty_eff);
      pwm_r_nxt = pwm_on && (color == COL_R);
      pwm_g_nxt = pwm_on && (color == COL_G);
      pwm_b_nxt = pwm_on && (color == COL_B);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_cnt    <= '0;
         state      <= IDLE;
         brightness <= '0;
         duty_eff   <= '0;
         period_cnt <= '0;
         color      <= '0;
         cycle_done <= 1'b0;
         pwm_r      <= 1'b0;
         pwm_g      <= 1'b0;
         pwm_b      <= 1'b0;
      end else begin
         pwm_cnt    <= pwm_cnt + CNT_W'(1);
         state      <= state_nxt;
         brightness <= bright_nxt;
         duty_eff   <= duty_nxt;
         period_cnt <= period_nxt;
         color      <= color_nxt;
         cycle_done <= done_nxt;
         pwm_r      <= pwm_r_nxt;
         pwm_g      <= pwm_g_nxt;
         pwm_b      <= pwm_b_nxt;
      end
   end

endmodule
